btn_event_decoder: RTL and testbench
====================================

Name: btn_event_decoder

Overview:
Sits directly downstream of the stopwatch debouncer and consumes its clean, active-high button level. Converts that level into single-cycle event pulses: press, short-press, long-press, release and optional auto-repeat. It also provides a held status level. The stopwatch control FSM uses these events for start/stop, lap and clear actions.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; TICK_DIV = CLK_FREQ/1000 clocks per 1 ms tick.
LONG_MS, 1000, hold time in ms before a press is classified as long.
REPEAT_MS, 200, auto-repeat period in ms; used only when BTN_AUTOREPEAT_EN is defined.

Ports:
clk  input  1  system clock, all state on rising edge
reset_n  input  1  asynchronous, active-low reset
btn_level  input  1  debounced button level, 1 = pressed, already synchronous to clk
press_pulse  output  1  one-cycle pulse on button press
short_pulse  output  1  one-cycle pulse on release before LONG_MS elapsed
long_pulse  output  1  one-cycle pulse when hold reaches LONG_MS
release_pulse  output  1  one-cycle pulse on any release
held  output  1  level, high while in HELD state
repeat_pulse  output  1  one-cycle auto-repeat pulse (constant 0 without macro)

Behaviour:
- Clock and reset: clk clocks all state; reset_n is asynchronous and active-low.
- Reset values: all outputs 0, state IDLE, prev_level 0, prescaler 0, ms counter 0.
  - A button held through reset deassertion produces press_pulse on the first sampled edge.
- Edge detect: prev_level <= btn_level every cycle.
  - rise = btn_level & ~prev_level; fall = ~btn_level & prev_level.
- All outputs are registered. A pulse is high for exactly one cycle, the cycle after the edge at which the condition was sampled.
- Prescaler: counts 0..TICK_DIV-1; tick = (presc == TICK_DIV-1); wraps to 0 on tick.
  - Cleared to 0 on rise.
  - Runs only in PRESSED and HELD; held at 0 in IDLE.
- Widths:
  - prescaler: $clog2(TICK_DIV) bits, minimum 1.
  - ms counter: $clog2(max(LONG_MS,REPEAT_MS)+1) bits.
  - No counter ever wraps past its terminal value.
- FSM states: IDLE, PRESSED, HELD.
  - IDLE:
    - rise -> press_pulse, ms_cnt<=0, go PRESSED.
    - fall in IDLE (only possible after reset glitch) is ignored.
  - PRESSED:
    - fall -> short_pulse and release_pulse together, go IDLE.
    - else, tick with ms_cnt==LONG_MS-1 -> long_pulse, ms_cnt<=0, go HELD.
    - else, on tick, ms_cnt increments.
  - HELD:
    - held=1.
    - fall -> release_pulse, held drops to 0 in the same cycle release_pulse rises, go IDLE.
    - Repeat behaviour per Optional Feature.
- Latency: long_pulse rises exactly LONG_MS*TICK_DIV clock cycles after press_pulse rises.
- Simultaneous events:
  - fall on the same edge as the terminal tick -> treated as short press (short_pulse + release_pulse, no long_pulse).
  - rise and fall cannot coincide (single-bit input).
- Re-press: rise on the cycle immediately after returning to IDLE is accepted normally.
- Reset mid-operation: any state returns to IDLE with outputs 0. No pulse is emitted on reset.
- Elaboration error if TICK_DIV < 1, LONG_MS < 1, or (macro defined and REPEAT_MS < 1).

Optional Feature:
BTN_AUTOREPEAT_EN
- Defined:
  - In HELD, ms_cnt counts ticks.
  - Tick with ms_cnt==REPEAT_MS-1 -> repeat_pulse, ms_cnt<=0.
  - First repeat_pulse comes REPEAT_MS*TICK_DIV cycles after long_pulse, then periodic.
  - fall on the same edge as a repeat tick -> release only, no repeat_pulse.
- Undefined: repeat_pulse tied to 0, no repeat comparator, ms counter frozen in HELD.

Test Plan:
1. CLK_FREQ=10_000 (TICK_DIV=10), LONG_MS=5, reset, btn_level=0 for 20 cycles -> all outputs 0.
2. Raise btn_level for 30 cycles then drop -> press_pulse one cycle after rise; short_pulse and release_pulse together one cycle after fall; no long_pulse, held stays 0.
3. Hold btn_level 80 cycles -> long_pulse exactly 50 cycles after press_pulse; held=1 from then; on drop release_pulse only, no short_pulse.
4. Drop btn_level on exactly cycle 49 after press_pulse (the terminal-tick edge) -> short_pulse + release_pulse, no long_pulse; then re-press the next cycle -> press_pulse again.
5. Assert reset_n=0 asynchronously mid-HELD -> outputs 0 immediately. Release reset with btn_level=1 -> press_pulse on the first edge.
6. With BTN_AUTOREPEAT_EN, REPEAT_MS=2, hold 100 cycles -> repeat_pulse at +20, +40 cycles after long_pulse. Without the macro -> repeat_pulse stays 0.

Source files
------------

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into press/short/long/release/repeat pulses.
// Define BTN_AUTOREPEAT_EN to enable repeat_pulse while the button is held.
module btn_event_decoder #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic release_pulse,
  output logic held,
  output logic repeat_pulse
);
  localparam int TICK_DIV = CLK_FREQ / 1000;
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_MS   = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int CW       = $clog2(MAX_MS + 1);

  if (TICK_DIV < 1) begin : g_err_div
    $error("TICK_DIV must be at least 1");
  end
  if (LONG_MS < 1) begin : g_err_long
    $error("LONG_MS must be at least 1");
  end
`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_MS < 1) begin : g_err_rep
    $error("REPEAT_MS must be at least 1");
  end
`endif

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  state_t          r_state, w_state_n;
  logic            r_prev;
  logic [PW-1:0]   r_presc, w_presc_n;
  logic [CW-1:0]   r_ms, w_ms_n;
  logic            r_press, r_short, r_long, r_rel, r_held;
  logic            w_press_n, w_short_n, w_long_n, w_rel_n;
  logic            w_rise, w_fall, w_tick;
`ifdef BTN_AUTOREPEAT_EN
  logic            r_rep, w_rep_n;
`endif

  assign w_rise = btn_level & ~r_prev;
  assign w_fall = ~btn_level & r_prev;
  assign w_tick = (r_presc == PW'(TICK_DIV - 1));

  always_comb begin
    w_state_n = r_state;
    w_ms_n    = r_ms;
    w_press_n = 1'b0;
    w_short_n = 1'b0;
    w_long_n  = 1'b0;
    w_rel_n   = 1'b0;
`ifdef BTN_AUTOREPEAT_EN
    w_rep_n   = 1'b0;
`endif
    case (r_state)
      IDLE: if (w_rise) begin
        w_press_n = 1'b1;
        w_ms_n    = '0;
        w_state_n = PRESSED;
      end
      PRESSED: if (w_fall) begin
        w_short_n = 1'b1;
        w_rel_n   = 1'b1;
        w_state_n = IDLE;
      end else if (w_tick) begin
        w_long_n  = (r_ms == CW'(LONG_MS - 1));
        w_ms_n    = w_long_n ? '0 : r_ms + 1'b1;
        w_state_n = w_long_n ? HELD : PRESSED;
      end
      HELD: if (w_fall) begin
        w_rel_n   = 1'b1;
        w_state_n = IDLE;
      end
`ifdef BTN_AUTOREPEAT_EN
      else if (w_tick) begin
        w_rep_n = (r_ms == CW'(REPEAT_MS - 1));
        w_ms_n  = w_rep_n ? '0 : r_ms + 1'b1;
      end
`endif
      default: w_state_n = IDLE;
    endcase
    // prescaler restarts on a press and rests at zero whenever the FSM is idle
    w_presc_n = (w_rise || w_state_n == IDLE || w_tick) ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_prev  <= 1'b0;
      r_presc <= '0;
      r_ms    <= '0;
      r_press <= 1'b0;
      r_short <= 1'b0;
      r_long  <= 1'b0;
      r_rel   <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_prev  <= btn_level;
      r_presc <= w_presc_n;
      r_ms    <= w_ms_n;
      r_press <= w_press_n;
      r_short <= w_short_n;
      r_long  <= w_long_n;
      r_rel   <= w_rel_n;
      r_held  <= (w_state_n == HELD);
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rep <= 1'b0;
    else          r_rep <= w_rep_n;
  end
  assign repeat_pulse = r_rep;
`else
  assign repeat_pulse = 1'b0;
`endif

  assign press_pulse   = r_press;
  assign short_pulse   = r_short;
  assign long_pulse    = r_long;
  assign release_pulse = r_rel;
  assign held          = r_held;
endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed checks of btn_event_decoder with TICK_DIV=10, LONG_MS=5, REPEAT_MS=2.
module tb_btn_event_decoder;
`ifdef BTN_AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam logic [5:0] PRESS = 6'b100000, SHORT_REL = 6'b010100, LONG_HELD = 6'b001010;
  localparam logic [5:0] HELD_ONLY = 6'b000010, REL = 6'b000100, REP = 6'b000001, NONE = 6'b000000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic btn_level = 1'b0;
  logic press_pulse, short_pulse, long_pulse, release_pulse, held, repeat_pulse;
  logic [5:0] outs;
  int checks = 0;
  int failures = 0;

  btn_event_decoder #(.CLK_FREQ(10_000), .LONG_MS(5), .REPEAT_MS(2)) dut (
    .clk(clk), .reset_n(reset_n), .btn_level(btn_level),
    .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
    .release_pulse(release_pulse), .held(held), .repeat_pulse(repeat_pulse)
  );

  always #5 clk = ~clk;
  assign outs = {press_pulse, short_pulse, long_pulse, release_pulse, held, repeat_pulse};

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b (press,short,long,rel,held,rep)", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      check(tag, outs, NONE);
    end
  endtask

  // steps n cycles in HELD; repeat pulses land every 20 cycles after long_pulse
  task automatic held_run(input string tag, input int n);
    for (int i = 1; i <= n; i++) begin
      step();
      check(tag, outs, HELD_ONLY | ((AR && i % 20 == 0) ? REP : NONE));
    end
  endtask

  task automatic press_to_long(input string tag);
    btn_level = 1'b1;
    step();
    check({tag, "_press"}, outs, PRESS);
    quiet({tag, "_wait"}, 49);
    step();
    check({tag, "_long"}, outs, LONG_HELD);
  endtask

  initial begin
    step();
    check("in_reset", outs, NONE);
    reset_n = 1'b1;
    quiet("idle", 20);

    btn_level = 1'b1;
    step();
    check("short_press", outs, PRESS);
    quiet("short_hold", 29);
    btn_level = 1'b0;
    step();
    check("short_rel", outs, SHORT_REL);
    step();
    check("short_after", outs, NONE);

    press_to_long("long");
    held_run("long_held", 29);
    btn_level = 1'b0;
    step();
    check("long_rel", outs, REL);
    step();
    check("long_after", outs, NONE);

    btn_level = 1'b1;
    step();
    check("edge_press", outs, PRESS);
    quiet("edge_wait", 49);
    btn_level = 1'b0;
    step();
    check("edge_short", outs, SHORT_REL);
    btn_level = 1'b1;
    step();
    check("repress", outs, PRESS);
    quiet("repress_wait", 49);
    step();
    check("repress_long", outs, LONG_HELD);
    held_run("pre_reset_held", 5);

    #2 reset_n = 1'b0;
    #1 check("async_reset", outs, NONE);
    step();
    check("reset_hold", outs, NONE);
    reset_n = 1'b1;
    step();
    check("press_after_reset", outs, PRESS);
    quiet("after_reset_wait", 49);
    step();
    check("after_reset_long", outs, LONG_HELD);
    btn_level = 1'b0;
    step();
    check("after_reset_rel", outs, REL);

    press_to_long("rep");
    held_run("rep_held", 49);
    btn_level = 1'b0;
    step();
    check("rep_rel", outs, REL);
    quiet("final_idle", 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
